// File: rtl/grid_collide_scan_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : grid_collide_scan_pkg
//  Purpose  : Shared geometry defaults, FSM state encoding and index/width
//             helpers for the grid collision scanner and its neighbours.
//  Revision : 1.0 - initial release
// ============================================================================
package grid_collide_scan_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } scan_state_e;

   localparam int DEF_W         = 10;
   localparam int DEF_ROWS      = 3;
   localparam int DEF_COLS      = 8;
   localparam int DEF_CELL_SIZE = 12;
   localparam int DEF_SPACING   = 60;
   localparam int DEF_OBJ_W     = 4;
   localparam int DEF_OBJ_H     = 8;

   // Bits needed to index n items; never less than one bit.
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Accumulator width: largest origin plus the farthest cell offset plus the
   // largest box extent must fit without wrapping.
   function automatic int acc_w(input int w, input int rows, input int cols,
                                input int cs, input int sp, input int ow,
                                input int oh);
      int span;
      span = (((rows > cols) ? rows : cols) - 1) * sp + cs + ((ow > oh) ? ow : oh);
      return $clog2((1 << w) + span);
   endfunction

endpackage
`default_nettype wire

// File: rtl/grid_collide_scan_if.sv
`default_nettype none
// ============================================================================
//  Module   : grid_collide_scan_if
//  Purpose  : Start/done request and result bundle between the motion logic
//             (master) and the grid collision scanner (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface grid_collide_scan_if #(
   parameter int W    = 10,
   parameter int ROWS = 3,
   parameter int COLS = 8
);
   import grid_collide_scan_pkg::*;

   localparam int RW = idx_w(ROWS);
   localparam int CW = idx_w(COLS);
   localparam int NW = idx_w(ROWS * COLS + 1);

   logic                   i_start;
   logic                   i_early_stop;
   logic                   i_obj_active;
   logic [W-1:0]           i_obj_x;
   logic [W-1:0]           i_obj_y;
   logic [W-1:0]           i_group_x;
   logic [W-1:0]           i_group_y;
   logic [ROWS*COLS-1:0]   i_alive;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_hit;
   logic [RW-1:0]          o_hit_row;
   logic [CW-1:0]          o_hit_col;
   logic [NW-1:0]          o_hit_count;

   modport master (
      output i_start, i_early_stop, i_obj_active, i_obj_x, i_obj_y,
             i_group_x, i_group_y, i_alive,
      input  o_busy, o_done, o_hit, o_hit_row, o_hit_col, o_hit_count
   );

   modport slave (
      input  i_start, i_early_stop, i_obj_active, i_obj_x, i_obj_y,
             i_group_x, i_group_y, i_alive,
      output o_busy, o_done, o_hit, o_hit_row, o_hit_col, o_hit_count
   );

endinterface
`default_nettype wire

// File: rtl/grid_collide_scan_aabb_overlap.sv
`default_nettype none
// ============================================================================
//  Module   : aabb_overlap
//  Purpose  : Combinational strict-overlap test of two axis-aligned boxes of
//             fixed size. Touching edges do not count as overlap.
//  Revision : 1.0 - initial release
// ============================================================================
module aabb_overlap #(
   parameter int AW  = 11,
   parameter int A_W = 4,
   parameter int A_H = 8,
   parameter int B_W = 12,
   parameter int B_H = 12
) (
   input  wire logic [AW-1:0] i_ax,
   input  wire logic [AW-1:0] i_ay,
   input  wire logic [AW-1:0] i_bx,
   input  wire logic [AW-1:0] i_by,
   output logic               o_overlap
);
   localparam logic [AW-1:0] c_A_W = AW'(A_W);
   localparam logic [AW-1:0] c_A_H = AW'(A_H);
   localparam logic [AW-1:0] c_B_W = AW'(B_W);
   localparam logic [AW-1:0] c_B_H = AW'(B_H);

   // AW is sized by the caller so none of these sums can wrap.
   assign o_overlap = (i_ax < i_bx + c_B_W) && (i_ax + c_A_W > i_bx) &&
                      (i_ay < i_by + c_B_H) && (i_ay + c_A_H > i_by);

endmodule
`default_nettype wire

// File: rtl/grid_collide_scan.sv
`default_nettype none
// ============================================================================
//  Module   : grid_collide_scan
//  Purpose  : Sequential object-versus-grid collision scan, one cell per
//             clock in row-major order; reports first hit and hit count.
//  Revision : 1.0 - initial release
// ============================================================================
module grid_collide_scan
   import grid_collide_scan_pkg::*;
#(
   parameter int W         = DEF_W,
   parameter int ROWS      = DEF_ROWS,
   parameter int COLS      = DEF_COLS,
   parameter int CELL_SIZE = DEF_CELL_SIZE,
   parameter int SPACING   = DEF_SPACING,
   parameter int OBJ_W     = DEF_OBJ_W,
   parameter int OBJ_H     = DEF_OBJ_H
) (
   input  wire logic         i_clk,
   input  wire logic         i_rst_n,
   grid_collide_scan_if.slave bus
);
   localparam int N  = ROWS * COLS;
   localparam int RW = idx_w(ROWS);
   localparam int CW = idx_w(COLS);
   localparam int IW = idx_w(N);
   localparam int NW = idx_w(N + 1);
   localparam int AW = acc_w(W, ROWS, COLS, CELL_SIZE, SPACING, OBJ_W, OBJ_H);

   localparam logic [1:0]    c_IDLE     = ST_IDLE;
   localparam logic [1:0]    c_SCAN     = ST_SCAN;
   localparam logic [1:0]    c_DONE     = ST_DONE;
   localparam logic [AW-1:0] c_SPACING  = AW'(SPACING);
   localparam logic [CW-1:0] c_LAST_COL = CW'(COLS - 1);
   localparam logic [IW-1:0] c_LAST_IDX = IW'(N - 1);

   logic [1:0]    r_state;
   logic          r_early;
   logic [AW-1:0] r_obj_x, r_obj_y, r_gx;
   logic [N-1:0]  r_alive;
   logic [RW-1:0] r_row;
   logic [CW-1:0] r_col;
   logic [IW-1:0] r_idx;
   logic [AW-1:0] r_ex, r_ey;
   logic          r_busy, r_done, r_hit;
   logic [RW-1:0] r_hit_row;
   logic [CW-1:0] r_hit_col;
   logic [NW-1:0] r_count;

   logic          w_overlap;
   logic          w_cell_hit;
   logic          w_last;

   aabb_overlap #(
      .AW  (AW),
      .A_W (OBJ_W),
      .A_H (OBJ_H),
      .B_W (CELL_SIZE),
      .B_H (CELL_SIZE)
   ) u_overlap (
      .i_ax      (r_obj_x),
      .i_ay      (r_obj_y),
      .i_bx      (r_ex),
      .i_by      (r_ey),
      .o_overlap (w_overlap)
   );

   assign w_cell_hit = r_alive[r_idx] && w_overlap;
   assign w_last     = (r_idx == c_LAST_IDX);

   // Scan FSM: latch request, walk cells with additive origin stepping, publish results.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state   <= c_IDLE;
         r_early   <= 1'b0;
         r_obj_x   <= '0;
         r_obj_y   <= '0;
         r_gx      <= '0;
         r_alive   <= '0;
         r_row     <= '0;
         r_col     <= '0;
         r_idx     <= '0;
         r_ex      <= '0;
         r_ey      <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hit     <= 1'b0;
         r_hit_row <= '0;
         r_hit_col <= '0;
         r_count   <= '0;
      end else begin
         r_busy <= (r_state != c_IDLE);
         r_done <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (bus.i_start) begin
                  r_early   <= bus.i_early_stop;
                  r_obj_x   <= {{(AW-W){1'b0}}, bus.i_obj_x};
                  r_obj_y   <= {{(AW-W){1'b0}}, bus.i_obj_y};
                  r_gx      <= {{(AW-W){1'b0}}, bus.i_group_x};
                  r_ex      <= {{(AW-W){1'b0}}, bus.i_group_x};
                  r_ey      <= {{(AW-W){1'b0}}, bus.i_group_y};
                  r_alive   <= bus.i_alive;
                  r_row     <= '0;
                  r_col     <= '0;
                  r_idx     <= '0;
                  r_hit     <= 1'b0;
                  r_hit_row <= '0;
                  r_hit_col <= '0;
                  r_count   <= '0;
                  // An inactive object skips straight to an empty result.
                  r_state   <= bus.i_obj_active ? c_SCAN : c_DONE;
               end
            end
            c_SCAN: begin
               if (w_cell_hit) begin
                  if (!r_hit) begin
                     r_hit     <= 1'b1;
                     r_hit_row <= r_row;
                     r_hit_col <= r_col;
                  end
                  r_count <= r_count + NW'(1);
               end
               if (w_last || (r_early && w_cell_hit)) begin
                  r_state <= c_DONE;
               end else begin
                  r_idx <= r_idx + IW'(1);
                  if (r_col == c_LAST_COL) begin
                     r_col <= '0;
                     r_row <= r_row + RW'(1);
                     r_ex  <= r_gx;
                     r_ey  <= r_ey + c_SPACING;
                  end else begin
                     r_col <= r_col + CW'(1);
                     r_ex  <= r_ex + c_SPACING;
                  end
               end
            end
            c_DONE: begin
               r_done  <= 1'b1;
               r_state <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign bus.o_busy      = r_busy;
   assign bus.o_done      = r_done;
   assign bus.o_hit       = r_hit;
   assign bus.o_hit_row   = r_hit_row;
   assign bus.o_hit_col   = r_hit_col;
   assign bus.o_hit_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_grid_collide_scan.sv
`default_nettype none
// ============================================================================
//  Module   : tb_grid_collide_scan
//  Purpose  : Directed scoreboard bench for grid_collide_scan (default grid
//             and an overlapping-cell SPACING=8 variant).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_grid_collide_scan;
   localparam int W    = 10;
   localparam int ROWS = 3;
   localparam int COLS = 8;
   localparam logic [23:0] ALL = 24'hFFFFFF;

   typedef struct {
      int id;
      int hit;
      int row;
      int col;
      int cnt;
      int cyc;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   cyc   = 0;
   int   tests = 0;
   int   failed = 0;
   int   k_last = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;

   always #5 clk = ~clk;

   // Edge counter: after posedge e (and until the next one) cyc == e.
   always @(posedge clk) cyc <= cyc + 1;

   grid_collide_scan_if #(.W(W), .ROWS(ROWS), .COLS(COLS)) bus0 ();
   grid_collide_scan_if #(.W(W), .ROWS(ROWS), .COLS(COLS)) bus1 ();

   grid_collide_scan #(.W(W), .ROWS(ROWS), .COLS(COLS)) dut0 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus0)
   );

   grid_collide_scan #(.W(W), .ROWS(ROWS), .COLS(COLS), .SPACING(8)) dut1 (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus1)
   );

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         failed++;
         $display("FAIL %s: got %0d required %0d", name, got, exp);
      end
   endtask

   // Monitor: compare every o_done against the oldest expected result.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus0.o_done) begin
            if (q0.size() == 0) begin
               chk("dut0 unexpected done", 1, 0);
            end else begin
               e0 = q0.pop_front();
               chk($sformatf("t%0d hit", e0.id),   int'(bus0.o_hit),       e0.hit);
               chk($sformatf("t%0d row", e0.id),   int'(bus0.o_hit_row),   e0.row);
               chk($sformatf("t%0d col", e0.id),   int'(bus0.o_hit_col),   e0.col);
               chk($sformatf("t%0d count", e0.id), int'(bus0.o_hit_count), e0.cnt);
               chk($sformatf("t%0d done edge", e0.id), cyc, e0.cyc);
            end
         end
         if (bus1.o_done) begin
            if (q1.size() == 0) begin
               chk("dut1 unexpected done", 1, 0);
            end else begin
               e1 = q1.pop_front();
               chk($sformatf("t%0d hit", e1.id),   int'(bus1.o_hit),       e1.hit);
               chk($sformatf("t%0d row", e1.id),   int'(bus1.o_hit_row),   e1.row);
               chk($sformatf("t%0d col", e1.id),   int'(bus1.o_hit_col),   e1.col);
               chk($sformatf("t%0d count", e1.id), int'(bus1.o_hit_count), e1.cnt);
               chk($sformatf("t%0d done edge", e1.id), cyc, e1.cyc);
            end
         end
      end
   end

   // Present one start pulse; the expected result is queued with its done edge.
   task automatic issue(input int sel, input int id, input int ox, input int oy,
                        input logic early, input logic act, input logic [23:0] alive,
                        input int eh, input int er, input int ec, input int en,
                        input int lat, input bit push);
      exp_t e;
      @(negedge clk);
      if (sel == 0) begin
         bus0.i_obj_x = W'(ox);  bus0.i_obj_y = W'(oy);
         bus0.i_early_stop = early; bus0.i_obj_active = act;
         bus0.i_alive = alive; bus0.i_start = 1'b1;
      end else begin
         bus1.i_obj_x = W'(ox);  bus1.i_obj_y = W'(oy);
         bus1.i_early_stop = early; bus1.i_obj_active = act;
         bus1.i_alive = alive; bus1.i_start = 1'b1;
      end
      @(posedge clk);
      #1;
      k_last = cyc;
      bus0.i_start = 1'b0;
      bus1.i_start = 1'b0;
      if (push) begin
         e = '{id: id, hit: eh, row: er, col: ec, cnt: en, cyc: k_last + lat};
         if (sel == 0) q0.push_back(e);
         else          q1.push_back(e);
      end
   endtask

   task automatic wait_done(input int sel, input int budget);
      bit pending;
      pending = 1'b1;
      for (int i = 0; i < budget && pending; i++) begin
         @(posedge clk);
         #2;
         pending = (sel == 0) ? (q0.size() != 0) : (q1.size() != 0);
      end
      if (pending) begin
         chk($sformatf("dut%0d done timeout", sel), 0, 1);
         if (sel == 0) q0.delete();
         else          q1.delete();
      end
   endtask

   initial begin
      bus0.i_start = 1'b0; bus0.i_early_stop = 1'b0; bus0.i_obj_active = 1'b0;
      bus0.i_obj_x = '0; bus0.i_obj_y = '0; bus0.i_alive = ALL;
      bus0.i_group_x = W'(100); bus0.i_group_y = W'(50);
      bus1.i_start = 1'b0; bus1.i_early_stop = 1'b0; bus1.i_obj_active = 1'b0;
      bus1.i_obj_x = '0; bus1.i_obj_y = '0; bus1.i_alive = ALL;
      bus1.i_group_x = W'(100); bus1.i_group_y = W'(50);

      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset busy",  int'(bus0.o_busy), 0);
      chk("reset done",  int'(bus0.o_done), 0);
      chk("reset hit",   int'(bus0.o_hit),  0);
      chk("reset count", int'(bus0.o_hit_count), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single hit at (0,1), full scan, done at k+25
      issue(0, 1, 165, 55, 1'b0, 1'b1, ALL, 1, 0, 1, 1, 25, 1'b1);
      @(posedge clk); #1;
      chk("t1 busy after start", int'(bus0.o_busy), 1);
      wait_done(0, 40);
      // 2: same object, cell 1 dead
      issue(0, 2, 165, 55, 1'b0, 1'b1, 24'hFFFFFD, 0, 0, 0, 0, 25, 1'b1);
      wait_done(0, 40);
      // 3: early stop at (2,1), index 17, done at k+19
      issue(0, 3, 160, 170, 1'b1, 1'b1, ALL, 1, 2, 1, 1, 19, 1'b1);
      wait_done(0, 40);
      // 4: edge boundaries around column 1 (x span 160..172)
      issue(0, 4, 156, 55, 1'b0, 1'b1, ALL, 0, 0, 0, 0, 25, 1'b1);
      wait_done(0, 40);
      issue(0, 5, 157, 55, 1'b0, 1'b1, ALL, 1, 0, 1, 1, 25, 1'b1);
      wait_done(0, 40);
      issue(0, 6, 172, 55, 1'b0, 1'b1, ALL, 0, 0, 0, 0, 25, 1'b1);
      wait_done(0, 40);
      // 5: SPACING=8; (102,52) covers cells (0,0),(1,0); (106,56) covers a 2x2 block
      issue(1, 7, 102, 52, 1'b0, 1'b1, ALL, 1, 0, 0, 2, 25, 1'b1);
      wait_done(1, 40);
      issue(1, 8, 106, 56, 1'b0, 1'b1, ALL, 1, 0, 0, 4, 25, 1'b1);
      wait_done(1, 40);
      // 6a: inactive object, previous hit result must clear, done at k+1
      issue(0, 9, 165, 55, 1'b0, 1'b1, ALL, 1, 0, 1, 1, 25, 1'b1);
      wait_done(0, 40);
      issue(0, 10, 165, 55, 1'b0, 1'b0, ALL, 0, 0, 0, 0, 1, 1'b1);
      wait_done(0, 10);
      // 6b: start pulsed mid-scan with different inputs is ignored
      issue(0, 11, 165, 55, 1'b0, 1'b1, ALL, 1, 0, 1, 1, 25, 1'b1);
      repeat (5) @(negedge clk);
      bus0.i_obj_x = W'(220); bus0.i_alive = '0; bus0.i_start = 1'b1;
      @(negedge clk);
      bus0.i_start = 1'b0;
      wait_done(0, 40);
      chk("t11 busy after done", int'(bus0.o_busy), 0);
      repeat (30) @(posedge clk);
      // 6c: reset at k+10 discards the scan in progress
      issue(0, 12, 165, 55, 1'b0, 1'b1, ALL, 0, 0, 0, 0, 0, 1'b0);
      repeat (10) @(posedge clk);
      #1;
      chk("t12 partial hit before reset", int'(bus0.o_hit), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("t12 reset hit",   int'(bus0.o_hit), 0);
      chk("t12 reset col",   int'(bus0.o_hit_col), 0);
      chk("t12 reset count", int'(bus0.o_hit_count), 0);
      chk("t12 reset busy",  int'(bus0.o_busy), 0);
      chk("t12 reset done",  int'(bus0.o_done), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      chk("t12 idle busy after reset", int'(bus0.o_busy), 0);
      // 13: back in IDLE, a fresh scan still works
      issue(0, 13, 160, 170, 1'b1, 1'b1, ALL, 1, 2, 1, 1, 19, 1'b1);
      wait_done(0, 40);
      repeat (3) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
